// File: rtl/slave_ctrl_pkg.sv
// Shared constants for the slave address front-end: FSM state encoding and
// the width of the address bit counter.
package slave_ctrl_pkg;

  // Address phase carries 8 bits (7 address + R/W), counted 0..7.
  localparam int BIT_CNT_W = 3;

  // FSM state encoding, kept as plain constants for legacy tooling.
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] CMP       = 3'd2;
  localparam logic [2:0] WAIT_FALL = 3'd3;
  localparam logic [2:0] ACK       = 3'd4;
  localparam logic [2:0] XFER      = 3'd5;
  localparam logic [2:0] IGNORE    = 3'd6;

endpackage

// File: rtl/slave_sync_edge.sv
// Multi-stage synchroniser for one raw bus line, followed by a history
// register so the caller gets the settled level plus one-cycle rise/fall
// strobes. All flops reset to 1, the idle level of an open-drain bus line.
module slave_sync_edge #(
  parameter int STAGES = 2  // synchroniser depth, must be at least 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the raw line through the synchroniser and remember the last level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/slave_addr_ctrl.sv
// Slave-side address front-end on the 16x oversampling clock. Detects
// START / STOP / repeated START on the synchronised bus, clocks the 8
// address+R/W bits into an external SIPO, compares the address and ACKs it
// on a match, then hands over to the data stage (XFER).
module slave_addr_ctrl
  import slave_ctrl_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       slave_scl_sixt,
  input  logic       slave_rst,
  input  logic       slave_scl_in,
  input  logic       slave_sda_in,
  input  logic [6:0] slave_addr_out,
  input  logic       slave_rd_wr,
  output logic       slave_serial_in,
  output logic       slave_rec_addr_shift,
  output logic       slave_sda_oe,
  output logic       slave_addr_match,
  output logic       slave_xfer_active,
  output logic       slave_rw_latched,
  output logic       slave_start_det,
  output logic       slave_stop_det
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  logic [2:0]           state_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic                 match_q;
  logic                 rw_q;
  logic                 start_det_q;
  logic                 stop_det_q;

  logic scl_high_steady;
  logic start_cond;
  logic stop_cond;
  logic start_eff;
  logic shift;

  slave_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk   (slave_scl_sixt),
    .rst   (slave_rst),
    .din   (slave_scl_in),
    .level (scl_s),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  slave_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk   (slave_scl_sixt),
    .rst   (slave_rst),
    .din   (slave_sda_in),
    .level (sda_s),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  // SCL high in both this and the previous sample; SDA moving inside that
  // window is a bus condition rather than data.
  assign scl_high_steady = scl_s & ~scl_rise;
  assign start_cond      = scl_high_steady & sda_fall;
  assign stop_cond       = scl_high_steady & sda_rise;

  // While we hold SDA low for the ACK, a falling SDA is our own doing and is
  // not taken as a START. A STOP is still honoured so the bus gets released.
  assign start_eff = start_cond & (state_q != ACK);

  // One shift per SCL rise during the address phase; the SIPO samples
  // slave_serial_in on the same clock edge.
  assign shift = (state_q == ADDR) & scl_rise & ~start_cond & ~stop_cond;

  // Main FSM: bus-condition overrides first, then the per-state sequence.
  always_ff @(posedge slave_scl_sixt) begin
    if (slave_rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      match_q     <= 1'b0;
      rw_q        <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      if (stop_cond) begin
        state_q    <= IDLE;
        bit_cnt_q  <= '0;
        match_q    <= 1'b0;
        rw_q       <= 1'b0;
        stop_det_q <= 1'b1;
      end else if (start_eff) begin
        state_q     <= ADDR;
        bit_cnt_q   <= '0;
        match_q     <= 1'b0;
        start_det_q <= 1'b1;
      end else begin
        case (state_q)
          ADDR: begin
            if (shift) begin
              if (bit_cnt_q == {BIT_CNT_W{1'b1}}) begin
                state_q   <= CMP;
                bit_cnt_q <= '0;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end
          CMP: begin
            // The SIPO took the 8th bit on the previous edge, so it is complete.
            match_q <= (slave_addr_out == SLAVE_ADDR);
            rw_q    <= slave_rd_wr;
            state_q <= WAIT_FALL;
          end
          WAIT_FALL: begin
            if (scl_fall) state_q <= match_q ? ACK : IGNORE;
          end
          ACK: begin
            if (scl_fall) state_q <= XFER;
          end
          IDLE, XFER, IGNORE: begin
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign slave_serial_in      = sda_s;
  assign slave_rec_addr_shift = shift;
  assign slave_sda_oe         = (state_q == ACK);
  assign slave_addr_match     = (state_q == ACK) | (state_q == XFER);
  assign slave_xfer_active    = (state_q == XFER);
  assign slave_rw_latched     = rw_q;
  assign slave_start_det      = start_det_q;
  assign slave_stop_det       = stop_det_q;

endmodule

// File: tb/tb_slave_addr_ctrl.sv
// Bench for slave_addr_ctrl: bus-level driver tasks, an external SIPO, a
// cycle-level protocol model compared on every cycle, and hand-computed
// checks per scenario collected into one counting process.
module tb_slave_addr_ctrl;

  localparam logic [6:0] OWN  = 7'h50;
  localparam int         SYNC = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       scl;
  logic       sda;
  logic [6:0] addr_out;
  logic       rd_wr;
  logic       serial_in, rec_shift, sda_oe, addr_match;
  logic       xfer_active, rw_latched, start_det, stop_det;

  slave_addr_ctrl #(.SLAVE_ADDR(OWN), .SYNC_STAGES(SYNC)) dut (
    .slave_scl_sixt       (clk),
    .slave_rst            (rst),
    .slave_scl_in         (scl),
    .slave_sda_in         (sda),
    .slave_addr_out       (addr_out),
    .slave_rd_wr          (rd_wr),
    .slave_serial_in      (serial_in),
    .slave_rec_addr_shift (rec_shift),
    .slave_sda_oe         (sda_oe),
    .slave_addr_match     (addr_match),
    .slave_xfer_active    (xfer_active),
    .slave_rw_latched     (rw_latched),
    .slave_start_det      (start_det),
    .slave_stop_det       (stop_det)
  );

  // External address SIPO: MSB first, last bit is R/W.
  logic [7:0] sipo;
  always @(posedge clk) begin
    if (rst) sipo <= 8'h00;
    else if (rec_shift) sipo <= {sipo[6:0], serial_in};
  end
  assign addr_out = sipo[7:1];
  assign rd_wr    = sipo[0];

  function automatic logic [7:0] dut_vec();
    return {serial_in, rec_shift, sda_oe, addr_match,
            xfer_active, rw_latched, start_det, stop_det};
  endfunction

  // ---------------- protocol model ----------------
  localparam int M_IDLE = 0, M_ADDR = 1, M_CMP = 2, M_WAITF = 3,
                 M_ACK = 4, M_XFER = 5, M_IGN = 6;
  bit         sh [0:SYNC];
  bit         dh [0:SYNC];
  int         phase;
  int         nbits;
  logic [7:0] mbyte;
  bit         mmatch, mrw, m_start, m_stop;
  bit         model_on = 1'b0;
  bit         m_sl, m_sp, m_dl, m_dp;

  always @(posedge clk) begin
    if (rst) begin
      foreach (sh[i]) sh[i] = 1'b1;
      foreach (dh[i]) dh[i] = 1'b1;
      phase = M_IDLE; nbits = 0; mbyte = 8'h00;
      mmatch = 1'b0; mrw = 1'b0; m_start = 1'b0; m_stop = 1'b0;
      model_on = 1'b1;
    end else begin
      m_sl = sh[SYNC-1]; m_sp = sh[SYNC];
      m_dl = dh[SYNC-1]; m_dp = dh[SYNC];
      m_start = 1'b0; m_stop = 1'b0;
      if (m_sl && m_sp && !m_dp && m_dl) begin
        phase = M_IDLE; mrw = 1'b0; m_stop = 1'b1;
      end else if (m_sl && m_sp && m_dp && !m_dl && phase != M_ACK) begin
        phase = M_ADDR; nbits = 0; m_start = 1'b1;
      end else begin
        case (phase)
          M_ADDR: if (m_sl && !m_sp) begin
            mbyte = {mbyte[6:0], m_dl};
            nbits++;
            if (nbits == 8) phase = M_CMP;
          end
          M_CMP: begin
            mrw = mbyte[0];
            mmatch = (mbyte[7:1] == OWN);
            phase = M_WAITF;
          end
          M_WAITF: if (!m_sl && m_sp) phase = mmatch ? M_ACK : M_IGN;
          M_ACK:   if (!m_sl && m_sp) phase = M_XFER;
          default: ;
        endcase
      end
      for (int i = SYNC; i > 0; i--) begin
        sh[i] = sh[i-1];
        dh[i] = dh[i-1];
      end
      sh[0] = scl;
      dh[0] = sda;
    end
  end

  function automatic logic [7:0] model_vec();
    return {dh[SYNC-1], (phase == M_ADDR) && sh[SYNC-1] && !sh[SYNC],
            phase == M_ACK, phase == M_ACK || phase == M_XFER,
            phase == M_XFER, mrw, m_start, m_stop};
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  string       name_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  c_got, c_exp;

  // Literal checks are posted by the stimulus thread into fixed ring slots.
  string       lit_name [256];
  logic [31:0] lit_got  [256];
  logic [31:0] lit_exp  [256];
  int          wr_idx = 0;
  int          rd_idx = 0;

  always @(negedge clk) begin
    if (model_on) begin
      c_got = dut_vec();
      c_exp = model_vec();
      n_tests++;
      if (c_got !== c_exp) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t got=%b expected=%b", $time, c_got, c_exp);
      end
    end
    while (rd_idx != wr_idx) begin
      n_tests++;
      if (lit_got[rd_idx % 256] !== lit_exp[rd_idx % 256]) begin
        n_fail++;
        $display("FAIL %s got=%0h expected=%0h", lit_name[rd_idx % 256],
                 lit_got[rd_idx % 256], lit_exp[rd_idx % 256]);
      end
      rd_idx++;
    end
  end

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    lit_name[wr_idx % 256] = name;
    lit_got[wr_idx % 256]  = got;
    lit_exp[wr_idx % 256]  = exp;
    wr_idx++;
  endtask

  // ---------------- monitor counters ----------------
  int         mon_shift = 0, mon_oe = 0, mon_start = 0, mon_stop = 0;
  logic [7:0] mon_bits = 8'h00;
  always @(negedge clk) begin
    if (rec_shift === 1'b1) begin
      mon_shift++;
      mon_bits = {mon_bits[6:0], serial_in};
    end
    if (sda_oe === 1'b1)    mon_oe++;
    if (start_det === 1'b1) mon_start++;
    if (stop_det === 1'b1)  mon_stop++;
  end

  // ---------------- driver tasks ----------------
  int half;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    wait_clk(half/2); sda = 1'b1;
    wait_clk(half/2); scl = 1'b1;
    wait_clk(half);   sda = 1'b0;
    wait_clk(half);   scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(half/2); sda = 1'b0;
    wait_clk(half/2); scl = 1'b1;
    wait_clk(half);   sda = 1'b1;
    wait_clk(half);
  endtask

  task automatic send_bit(input bit b);
    wait_clk(half/2); sda = b;
    wait_clk(half/2); scl = 1'b1;
    wait_clk(half);   scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  // Ninth clock with SDA released by the master; checks the slave's drive.
  task automatic ack_bit(input bit exp_ack);
    wait_clk(half/2); sda = 1'b1;
    wait_clk(half/2); scl = 1'b1;
    wait_clk(half/2);
    lit("ack_oe", 32'(sda_oe), 32'(exp_ack));
    lit("ack_match", 32'(addr_match), 32'(exp_ack));
    wait_clk(half - half/2); scl = 1'b0;
  endtask

  // Full address phase with literal checks on pulses, bits and ACK timing.
  task automatic addr_phase(input logic [7:0] b);
    int  s0, o0;
    bit  hit;
    hit = (b[7:1] == OWN);
    s0 = mon_shift;
    send_byte(b);
    lit("shift_count", 32'(mon_shift - s0), 32'd8);
    lit("shift_bits", 32'(mon_bits), 32'(b));
    o0 = mon_oe;
    ack_bit(hit);
    wait_clk(half/2);
    lit("oe_cycles", 32'(mon_oe - o0), hit ? 32'(2*(half/2) + half) : 32'd0);
    lit("xfer_active", 32'(xfer_active), 32'(hit));
    lit("oe_released", 32'(sda_oe), 32'd0);
    if (hit) lit("rw_latched", 32'(rw_latched), 32'(b[0]));
  endtask

  // ---------------- stimulus ----------------
  int         p0;
  logic [7:0] rb;
  int         nb;

  initial begin
    rst = 1'b1; scl = 1'b1; sda = 1'b1; half = 8;
    wait_clk(3);
    lit("reset_outputs", 32'(dut_vec()), 32'h80);
    rst = 1'b0;
    wait_clk(4);

    // Matching write
    p0 = mon_start;
    bus_start();
    lit("start_det_pulse", 32'(mon_start - p0), 32'd1);
    addr_phase(8'hA0);
    send_byte(8'h3C); send_bit(1'b1);
    p0 = mon_stop;
    bus_stop();
    lit("stop_det_pulse", 32'(mon_stop - p0), 32'd1);
    lit("idle_after_stop", 32'(dut_vec()), 32'h80);

    // Address mismatch, read
    bus_start();
    addr_phase(8'hA3);
    send_byte(8'h55); send_bit(1'b1);
    lit("ignore_no_oe", 32'(sda_oe), 32'd0);
    p0 = mon_stop;
    bus_stop();
    lit("stop_after_ignore", 32'(mon_stop - p0), 32'd1);

    // Matching read, match held across data until STOP
    bus_start();
    addr_phase(8'hA1);
    send_byte(8'hC3); send_bit(1'b1);
    lit("read_match_held", 32'(addr_match), 32'd1);
    lit("read_rw_held", 32'(rw_latched), 32'd1);
    bus_stop();
    lit("read_match_clear", 32'(addr_match), 32'd0);
    lit("read_rw_clear", 32'(rw_latched), 32'd0);

    // Repeated START after 4 address bits
    bus_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    p0 = mon_start;
    bus_start();
    lit("rep_start_pulse", 32'(mon_start - p0), 32'd1);
    addr_phase(8'hA0);
    bus_stop();

    // STOP while the slave is ACKing
    bus_start();
    send_byte(8'hA0);
    wait_clk(half/2); sda = 1'b0;
    wait_clk(half/2); scl = 1'b1;
    wait_clk(half/2);
    lit("ack_before_stop", 32'(sda_oe), 32'd1);
    p0 = mon_stop;
    sda = 1'b1;
    wait_clk(half);
    lit("stop_in_ack_pulse", 32'(mon_stop - p0), 32'd1);
    lit("stop_in_ack_outputs", 32'(dut_vec()), 32'h80);

    // Reset in XFER, then a fresh matching address
    bus_start();
    addr_phase(8'hA0);
    wait_clk(2);
    rst = 1'b1;
    wait_clk(1);
    lit("reset_in_xfer", 32'(dut_vec()), 32'h80);
    rst = 1'b0;
    wait_clk(2);
    bus_start();
    addr_phase(8'hA0);
    bus_stop();

    // Randomised transactions
    for (int it = 0; it < 30; it++) begin
      half = $urandom_range(8, 14);
      case ($urandom_range(0, 3))
        0:       rb = 8'hA0;
        1:       rb = 8'hA1;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      bus_start();
      if ($urandom_range(0, 3) == 0) begin
        nb = $urandom_range(1, 7);
        for (int k = 0; k < nb; k++) send_bit(1'($urandom_range(0, 1)));
        bus_start();
      end
      addr_phase(rb);
      nb = $urandom_range(0, 2);
      for (int k = 0; k < nb; k++) begin
        send_byte(8'($urandom_range(0, 255)));
        send_bit(1'b1);
      end
      if ($urandom_range(0, 3) != 0) begin
        p0 = mon_stop;
        bus_stop();
        lit("rand_stop_pulse", 32'(mon_stop - p0), 32'd1);
      end
    end
    bus_stop();

    wait_clk(4);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
